xadc_sample_buffer: RTL and testbench

Downstream stage of the XADC capture block: takes the 12-bit Vp/Vn result, the 12-bit temperature result and the end-of-sequence pulse. It averages a power-of-two number of consecutive voltage samples into one output word. Averaged words go into a FIFO, which a consumer (UART framer, logger) drains through a valid/ready handshake. The latest temperature is kept in a separate register.

---
 rtl/xadc_sample_buffer_if.sv | 11 +
 rtl/xadc_sample_buffer.sv | 143 ++++++++++++++
 tb/tb_xadc_sample_buffer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/xadc_sample_buffer_if.sv
// Read-side handshake of the XADC sample buffer: valid/ready plus 12-bit word.
// Master drives data/valid, slave answers with ready; no internal latency.
// Backpressure: slave holds rd_ready low to stall; master holds rd_data meanwhile.
interface xadc_sample_buffer_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [11:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/xadc_sample_buffer.sv
// Averages 2^AVG_LOG2 XADC samples per new_data edge into a FIFO; optional drop counter via XBUF_DROP_CNT_EN.
// Latency: final-sample edge at N gives rd_valid/level at N+1; temp_latest at N+1.
// Backpressure: rd_ready low stalls the FIFO; a push into a full FIFO without a pop is dropped and flags overflow.
module xadc_sample_buffer #(
  parameter int AVG_LOG2   = 3,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           xadc_in,
  input  logic [11:0]           temp_in,
  input  logic                  new_data,
  input  logic                  clr_ovf,
  xadc_sample_buffer_if.master  rd,
  output logic [11:0]           temp_latest,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
`ifdef XBUF_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = 12 + AVG_LOG2;
  localparam int CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);

  logic                  new_q;
  logic                  evt;
  logic [SW-1:0]         sum;
  logic [SW-1:0]         sum_plus;
  logic [CW-1:0]         cnt;
  logic                  last;
  logic [11:0]           avg;

  logic [11:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic                  drop;

  assign evt      = new_data & ~new_q;
  assign sum_plus = sum + SW'(xadc_in);
  assign last     = (AVG_LOG2 == 0) || (cnt == {CW{1'b1}});
  // With AVG_LOG2=0 sum stays zero, so avg is xadc_in unchanged.
  assign avg      = sum_plus[SW-1:AVG_LOG2];

  assign push     = evt & last;
  assign rd.rd_valid = (level != '0);
  assign pop      = rd.rd_valid & rd.rd_ready;
  assign full     = (level == LVL_FULL);
  assign push_ok  = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level;
    if (pop)
      rd_ptr_nxt = rd_ptr + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      new_q       <= 1'b0;
      sum         <= '0;
      cnt         <= '0;
      temp_latest <= '0;
    end else begin
      new_q <= new_data;
      if (evt) begin
        temp_latest <= temp_in;
        if (last) begin
          sum <= '0;
          cnt <= '0;
        end else begin
          sum <= sum_plus;
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= avg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rd.rd_data <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      // Head register: bypass the RAM when the word being written becomes the new head.
      if (level_nxt != '0)
        rd.rd_data <= (push_ok && (wr_ptr == rd_ptr_nxt)) ? avg : mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clr_ovf)
      overflow <= 1'b0;
  end

`ifdef XBUF_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (drop && clr_ovf)
      drop_cnt <= 16'd1;
    else if (drop) begin
      if (drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end else if (clr_ovf)
      drop_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_xadc_sample_buffer.sv
// Scoreboard bench for xadc_sample_buffer (AVG_LOG2=2, DEPTH_LOG2=2): directed scenarios then random traffic.
// Reference model keeps samples and FIFO contents as queues; monitor compares on every falling edge.
module tb_xadc_sample_buffer;
  localparam int AVG   = 2;
  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;
  localparam int NAVG  = 1 << AVG;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] xadc_in = '0;
  logic [11:0] temp_in = '0;
  logic        new_data = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [11:0] temp_latest;
  logic [DL:0] level;
  logic        overflow;
`ifdef XBUF_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  xadc_sample_buffer_if rif ();

  xadc_sample_buffer #(.AVG_LOG2(AVG), .DEPTH_LOG2(DL)) dut (
    .clk         (clk),
    .rst         (rst),
    .xadc_in     (xadc_in),
    .temp_in     (temp_in),
    .new_data    (new_data),
    .clr_ovf     (clr_ovf),
    .rd          (rif),
    .temp_latest (temp_latest),
    .level       (level),
    .overflow    (overflow)
`ifdef XBUF_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  int exp_q[$];
  int samp[$];
  bit m_prev;
  int m_temp;
  bit m_ovf;
  int m_drop;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: updates on the same edges as the DUT, from the rules in plain arithmetic.
  always @(posedge clk or negedge rst) begin
    bit drop;
    int s;
    drop = 1'b0;
    s = 0;
    if (!rst) begin
      exp_q.delete();
      samp.delete();
      m_prev = 1'b0;
      m_temp = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (new_data && !m_prev) begin
        m_temp = temp_in;
        samp.push_back(int'(xadc_in));
        if (samp.size() == NAVG) begin
          foreach (samp[i]) s += samp[i];
          samp.delete();
          // monitor has already removed this cycle's pop from exp_q
          if (exp_q.size() < DEPTH) exp_q.push_back(s / NAVG);
          else drop = 1'b1;
        end
      end
      m_prev = new_data;
      if (drop) begin
        m_ovf = 1'b1;
        if (clr_ovf) m_drop = 1;
        else if (m_drop < 65535) m_drop++;
      end else if (clr_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
    end
  end

  // Monitor: compare DUT outputs to model, pop expected word when consumer accepts.
  always @(negedge clk) begin
    chk("rd_valid", 32'(rif.rd_valid), (exp_q.size() > 0) ? 1 : 0);
    chk("level", 32'(level), exp_q.size());
    chk("overflow", 32'(overflow), int'(m_ovf));
    chk("temp_latest", 32'(temp_latest), m_temp);
`ifdef XBUF_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), m_drop);
`endif
    if (!rst) begin
      chk("rd_data_in_reset", 32'(rif.rd_data), 0);
    end else if (exp_q.size() > 0) begin
      chk("rd_data", 32'(rif.rd_data), exp_q[0]);
      if (rif.rd_ready) void'(exp_q.pop_front());
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ev(input int x);
    new_data = 1'b1;
    xadc_in  = 12'(x);
    temp_in  = 12'($urandom_range(0, 4095));
    step();
    new_data = 1'b0;
    step();
  endtask

  initial begin
    int rdprob;
    rif.rd_ready = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);

    // Averaging: 100,101,102,104 -> 101
    ev(100); ev(101); ev(102); ev(104);
    step(2);
    rif.rd_ready = 1'b1;
    step(3);
    rif.rd_ready = 1'b0;

    // new_data held high counts once
    new_data = 1'b1;
    xadc_in  = 12'hABC;
    temp_in  = 12'h5A5;
    step(5);
    new_data = 1'b0;
    step();
    ev(12'hABC); ev(12'hABC); ev(12'hABC);
    step(2);

    // Fill past full with no reads: overflow
    for (int w = 0; w < 4 * NAVG; w++) ev($urandom_range(0, 4095));
    step(2);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    step(2);

    // Final sample while full with a simultaneous pop
    for (int k = 0; k < NAVG - 1; k++) ev($urandom_range(0, 4095));
    new_data = 1'b1;
    xadc_in  = 12'($urandom_range(0, 4095));
    rif.rd_ready = 1'b1;
    step();
    new_data = 1'b0;
    rif.rd_ready = 1'b0;
    step(2);
    rif.rd_ready = 1'b1;
    step(6);

    // Reset mid-average discards the partial sum
    rif.rd_ready = 1'b0;
    for (int k = 0; k < NAVG + 1; k++) ev($urandom_range(0, 4095));
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    for (int k = 0; k < NAVG; k++) ev(200);
    rif.rd_ready = 1'b1;
    step(4);

    // Random traffic with varying consumer speed
    rdprob = 50;
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) rdprob = (c / 500 % 3 == 0) ? 5 : ((c / 500 % 3 == 1) ? 50 : 95);
      new_data     = 1'($urandom_range(0, 1));
      xadc_in      = 12'($urandom_range(0, 4095));
      temp_in      = 12'($urandom_range(0, 4095));
      rif.rd_ready = ($urandom_range(0, 99) < rdprob);
      clr_ovf      = ($urandom_range(0, 99) == 0);
      rst          = ($urandom_range(0, 1999) != 0);
      step();
    end
    rst      = 1'b1;
    new_data = 1'b0;
    clr_ovf  = 1'b0;
    rif.rd_ready = 1'b1;
    step(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
